// File: rtl/sub_serial.sv
// sub_serial: bit-serial a - b (LSB first) with busy/done/borrow; SUB_SERIAL_OVF_EN adds a signed-overflow port ovf.
// Latency: done and the result appear WIDTH edges after the edge that accepts en. Back-to-back period is WIDTH+2 cycles.
// Backpressure: none; en is sampled only in IDLE and ignored while busy.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             borrow
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count;
    logic             brw;
    logic             d;
    logic             brw_next;
    logic             last;

    // One-bit full subtractor on the current LSBs.
    assign d        = a_reg[0] ^ b_reg[0] ^ brw;
    assign brw_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw);
    assign last     = (count == CW'(WIDTH - 1));

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = SUB;
            SUB:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            count  <= '0;
            brw    <= 1'b0;
            borrow <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        a_reg <= a;
                        b_reg <= b;
                        out   <= '0;
                        count <= '0;
                        brw   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                SUB: begin
                    brw   <= brw_next;
                    out   <= {d, out[WIDTH-1:1]};
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                    if (last) begin
                        borrow <= brw_next;
`ifdef SUB_SERIAL_OVF_EN
                        // At the last step the LSBs are the operand sign bits.
                        ovf    <= (a_reg[0] != b_reg[0]) && (d != a_reg[0]);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: randomized and directed operations scored against an arithmetic model.
module tb_sub_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         borrow;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    sub_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .out    (out),
        .busy   (busy),
        .done   (done),
        .borrow (borrow)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         brw;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    logic chk_en   = 1'b0;
    logic exp_busy = 1'b0;
    logic exp_d;
    exp_t cur;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; the model result is plain modular arithmetic on the operands.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        exp_t         e;
        logic [W-1:0] r;
        a  = x;
        b  = y;
        en = 1'b1;
        tick();
        r     = x - y;
        e.r   = r;
        e.brw = (x < y);
        e.ovf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        e.cyc = cyc + W;
        sb.push_back(e);
        if (!hold) en = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        exp_busy = 1'b1;
        repeat (W) tick();
        tick();
        exp_busy = 1'b0;
    endtask

    // Monitor: busy every cycle; done only on the cycle the model predicts, then result compare.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            exp_d = 1'b0;
            if (sb.size() > 0) begin
                if (sb[0].cyc == cyc) exp_d = 1'b1;
            end
            chk("done", 32'(done), 32'(exp_d));
            if (exp_d) begin
                cur = sb.pop_front();
                chk("out", 32'(out), 32'(cur.r));
                chk("borrow", 32'(borrow), 32'(cur.brw));
`ifdef SUB_SERIAL_OVF_EN
                chk("ovf", 32'(ovf), 32'(cur.ovf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) tick();
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (5) begin
            tick();
            chk("idle_out", 32'(out), 32'd0);
            chk("idle_borrow", 32'(borrow), 32'd0);
        end

        run_op(8'd200, 8'd55, 1'b0);
        run_op(8'd5, 8'd10, 1'b0);
        run_op(8'hA5, 8'hA5, 1'b0);

        // en held high: starts every W+2 cycles, operands scrambled during SUB.
        run_op(8'hFF, 8'h01, 1'b1);
        run_op(8'h00, 8'h01, 1'b1);
        run_op(8'hFF, 8'h01, 1'b1);
        run_op(8'h00, 8'h01, 1'b0);

        // Reset in the middle of an operation: no done pulse, clean state.
        a  = 8'h37;
        b  = 8'h12;
        en = 1'b1;
        tick();
        en       = 1'b0;
        exp_busy = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        exp_busy = 1'b0;
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        repeat (W + 3) tick();
        run_op(8'd9, 8'd3, 1'b0);

        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h01, 8'h80, 1'b0);
        run_op(8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if (!en) repeat ($urandom_range(0, 3)) tick();
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        run_op(W'($urandom), W'($urandom), 1'b0);

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
